// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command framer
package uart_cmd_pkg;

    localparam int CMD_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        B1,
        B2,
        CS,
        CMPL
    } state_t;

    // Opcodes understood by the downstream command dispatcher
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h05;

    function automatic logic [7:0] byte_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/uart_cmd_tmr.sv
// rtl/uart_cmd_tmr.sv - clearable inter-byte timeout counter with expiry flag
module uart_cmd_tmr #(
    parameter int TO_CYCLES = 208320,
    parameter int TO_W      = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    assign expired = (cnt == TO_W'(TO_CYCLES - 1));

    // Saturates at the expiry value so a late clear never sees a wrapped count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-to-command framer; UART_CMD_CHKSUM_EN adds a checksum byte and chk_err
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TO_CYCLES = 208320,
    parameter int TO_W      = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [7:0]       rx_data,
    output logic             clr_rx_rdy,
    output logic             cmd_rdy,
    output logic [CMD_W-1:0] cmd,
    input  logic             clr_cmd_rdy,
    output logic             ovr_err,
    output logic             to_err,
`ifdef UART_CMD_CHKSUM_EN
    output logic             chk_err,
`endif
    input  logic             clr_err
);

    state_t     state, state_nxt;
    logic [7:0] op_r, hi_r, lo_r;
    logic       rx_seen;
    logic       accept;
    logic       in_frame;
    logic       tmr_exp;
    logic       timeout;
    logic       frame_ok;
    logic       can_load;
    logic       publish;
    logic       ovr_set;

    // A byte is taken once per rdy assertion; rdy held across edges is not re-read
    assign accept     = rx_rdy && !rx_seen && (state != CMPL);
    assign clr_rx_rdy = accept && !rst;
    assign in_frame   = (state == B1) || (state == B2) || (state == CS);
    assign timeout    = in_frame && tmr_exp && !accept;
    assign can_load   = !cmd_rdy || clr_cmd_rdy;
    assign publish    = (state == CMPL) && frame_ok && can_load;
    assign ovr_set    = (state == CMPL) && frame_ok && !can_load;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] cs_r;
    assign frame_ok = (byte_sum(op_r, hi_r, lo_r, cs_r) == 8'h00);
`else
    assign frame_ok = 1'b1;
`endif

    uart_cmd_tmr #(
        .TO_CYCLES(TO_CYCLES),
        .TO_W     (TO_W)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || !in_frame || timeout),
        .en     (in_frame),
        .expired(tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = B1;
            B1: begin
                if (accept)       state_nxt = B2;
                else if (timeout) state_nxt = IDLE;
            end
            B2: begin
`ifdef UART_CMD_CHKSUM_EN
                if (accept)       state_nxt = CS;
`else
                if (accept)       state_nxt = CMPL;
`endif
                else if (timeout) state_nxt = IDLE;
            end
            CS: begin
                if (accept)       state_nxt = CMPL;
                else if (timeout) state_nxt = IDLE;
            end
            CMPL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_seen <= 1'b0;
            op_r    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
`ifdef UART_CMD_CHKSUM_EN
            cs_r    <= '0;
            chk_err <= 1'b0;
`endif
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            ovr_err <= 1'b0;
            to_err  <= 1'b0;
        end else begin
            rx_seen <= rx_rdy && (rx_seen || accept);
            if (accept) begin
                case (state)
                    IDLE:    op_r <= rx_data;
                    B1:      hi_r <= rx_data;
                    B2:      lo_r <= rx_data;
`ifdef UART_CMD_CHKSUM_EN
                    CS:      cs_r <= rx_data;
`endif
                    default: ;
                endcase
            end
            // A fresh command in the same cycle as the acknowledge keeps cmd_rdy high
            if (publish) begin
                cmd     <= {op_r, hi_r, lo_r};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            ovr_err <= ovr_set || (ovr_err && !clr_err);
            to_err  <= timeout || (to_err && !clr_err);
`ifdef UART_CMD_CHKSUM_EN
            chk_err <= ((state == CMPL) && !frame_ok) || (chk_err && !clr_err);
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed scoreboard bench for uart_cmd_ctrl (honours UART_CMD_CHKSUM_EN)
module tb_uart_cmd_ctrl;

    localparam int TO_CYC = 50;
`ifdef UART_CMD_CHKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [23:0] cmd;
    logic        clr_cmd_rdy = 1'b0;
    logic        ovr_err;
    logic        to_err;
    logic        clr_err = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    logic        chk_err;
`endif

    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    int          clr_cnt = 0;
    logic [23:0] exp_q[$];

    uart_cmd_ctrl #(
        .TO_CYCLES(TO_CYC),
        .TO_W     (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ovr_err    (ovr_err),
        .to_err     (to_err),
`ifdef UART_CMD_CHKSUM_EN
        .chk_err    (chk_err),
`endif
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (clr_rx_rdy) clr_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        tick();
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                              input int gap, input bit push);
        if (push) exp_q.push_back({op, hi, lo});
        send_byte(op);
        repeat (gap) tick();
        send_byte(hi);
        repeat (gap) tick();
        send_byte(lo);
`ifdef UART_CMD_CHKSUM_EN
        repeat (gap) tick();
        send_byte(8'h00 - (op + hi + lo));
`endif
    endtask

    task automatic expect_cmd(input string tag);
        logic [23:0] exp;
        int n;
        n = 0;
        while (!cmd_rdy && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        chk(tag, 32'(cmd), 32'(exp));
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        // Reset: consume pulse must be suppressed while rst is high
        rx_rdy = 1'b1;
        #1;
        chk("rst_clr_rx", 32'(clr_rx_rdy), 32'd0);
        tick();
        rx_rdy = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_ovr", 32'(ovr_err), 32'd0);
        chk("rst_to", 32'(to_err), 32'd0);

        // Spaced bytes, latency and one consume pulse per byte
        clr_cnt = 0;
        send_frame(8'h05, 8'hAB, 8'hCD, 30, 1'b1);
        chk("lat_early", 32'(cmd_rdy), 32'd0);
        tick();
        chk("lat_edge", 32'(cmd_rdy), 32'd1);
        expect_cmd("f1_cmd");
        chk("f1_clr_pulses", 32'(clr_cnt), 32'(FRAME_LEN));
        ack();
        chk("f1_ack", 32'(cmd_rdy), 32'd0);

        // rdy held three cycles for one byte
        clr_cnt = 0;
        exp_q.push_back(24'h7E0102);
        rx_rdy  = 1'b1;
        rx_data = 8'h7E;
        repeat (3) tick();
        rx_rdy  = 1'b0;
        tick();
        chk("hold_once", 32'(clr_cnt), 32'd1);
        send_byte(8'h01);
        tick();
        send_byte(8'h02);
`ifdef UART_CMD_CHKSUM_EN
        tick();
        send_byte(8'h00 - (8'h7E + 8'h01 + 8'h02));
`endif
        expect_cmd("hold_cmd");
        ack();

        // Partial frame abandoned exactly TO_CYC cycles after the last byte
        send_byte(8'h05);
        tick();
        send_byte(8'hAB);
        repeat (TO_CYC - 1) tick();
        chk("to_before", 32'(to_err), 32'd0);
        tick();
        chk("to_set", 32'(to_err), 32'd1);
        pulse_clr_err();
        chk("to_clr", 32'(to_err), 32'd0);
        send_frame(8'h11, 8'h22, 8'h33, 2, 1'b1);
        expect_cmd("after_to_cmd");
        ack();

        // Byte arriving on the expiry cycle is accepted
        exp_q.push_back(24'h05AB01);
        send_byte(8'h05);
        repeat (TO_CYC - 1) tick();
        send_byte(8'hAB);
        chk("expiry_byte_wins", 32'(to_err), 32'd0);
        tick();
        send_byte(8'h01);
`ifdef UART_CMD_CHKSUM_EN
        tick();
        send_byte(8'h00 - (8'h05 + 8'hAB + 8'h01));
`endif
        expect_cmd("expiry_cmd");
        ack();

        // Overrun: second frame dropped while first still pending
        send_frame(8'hA1, 8'hA2, 8'hA3, 1, 1'b1);
        expect_cmd("ovr_first");
        send_frame(8'hB1, 8'hB2, 8'hB3, 1, 1'b0);
        tick();
        tick();
        chk("ovr_cmd_kept", 32'(cmd), 32'h00A1A2A3);
        chk("ovr_set", 32'(ovr_err), 32'd1);
        pulse_clr_err();
        chk("ovr_clr", 32'(ovr_err), 32'd0);

        // Acknowledge coincident with the publish cycle
        send_frame(8'hC1, 8'hC2, 8'hC3, 1, 1'b1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("coinc_rdy", 32'(cmd_rdy), 32'd1);
        chk("coinc_ovr", 32'(ovr_err), 32'd0);
        expect_cmd("coinc_cmd");

        // Reset in the middle of a frame
        send_byte(8'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
        chk("mid_rst_cmd", 32'(cmd), 32'd0);
        chk("mid_rst_errs", {30'd0, ovr_err, to_err}, 32'd0);
        send_frame(8'h3C, 8'h4D, 8'h5E, 1, 1'b1);
        expect_cmd("post_rst_cmd");
        ack();

`ifdef UART_CMD_CHKSUM_EN
        // Checksum good then bad
        send_frame(8'h01, 8'h02, 8'h03, 1, 1'b1);
        expect_cmd("cs_good");
        ack();
        send_byte(8'h01);
        tick();
        send_byte(8'h02);
        tick();
        send_byte(8'h03);
        tick();
        send_byte(8'hFB);
        tick();
        tick();
        chk("cs_bad_rdy", 32'(cmd_rdy), 32'd0);
        chk("cs_bad_err", 32'(chk_err), 32'd1);
        pulse_clr_err();
        chk("cs_err_clr", 32'(chk_err), 32'd0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
